// File: rtl/dcache_miss_unit_pkg.sv
// Shared types, sizing constants and address helpers for the D-cache miss unit.
// Line/beat geometry here is the single place to retarget the unit.
package dcache_miss_unit_pkg;

  localparam int unsigned Plen      = 32;
  localparam int unsigned LineW     = 256;
  localparam int unsigned SetAssocW = 2;
  localparam int unsigned IndexW    = 7;
  localparam int unsigned BeatW     = 64;
  localparam int unsigned Beats     = LineW / BeatW;
  localparam int unsigned CntW      = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned BeatBytes = BeatW / 8;

  typedef enum logic [2:0] {StIdle, StWb, StRdReq, StRdWait, StRefill} miss_state_e;

  typedef logic [Plen-1:0]  paddr_t;
  typedef logic [LineW-1:0] line_t;
  typedef logic [BeatW-1:0] beat_t;
  typedef logic [CntW-1:0]  cnt_t;

  function automatic paddr_t line_base(paddr_t paddr);
    return paddr & ~paddr_t'(LineW / 8 - 1);
  endfunction

  function automatic paddr_t beat_addr(paddr_t base, cnt_t idx);
    return base + paddr_t'(idx) * paddr_t'(BeatBytes);
  endfunction

  function automatic beat_t get_beat(line_t line, cnt_t idx);
    return line[idx*BeatW +: BeatW];
  endfunction

endpackage

// File: rtl/dcache_miss_unit_if.sv
// Cache-side (miss/writeback/refill) and memory-side beat bus of the miss unit.
// master = the miss unit, slave = the D-cache plus memory environment.
interface dcache_miss_unit_if;
  import dcache_miss_unit_pkg::*;

  logic                 miss_req_valid;
  logic                 miss_req_ready;
  paddr_t               miss_req_paddr;
  logic [SetAssocW-1:0] miss_req_way;
  logic [IndexW-1:0]    miss_req_index;

  logic                 refill_valid;
  logic                 refill_ready;
  paddr_t               refill_paddr;
  logic [SetAssocW-1:0] refill_way;
  line_t                refill_data;

  logic                 wb_req_valid;
  logic                 wb_req_ready;
  paddr_t               wb_req_paddr;
  line_t                wb_req_data;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_we;
  paddr_t               mem_req_addr;
  beat_t                mem_req_wdata;
  logic                 mem_resp_valid;
  beat_t                mem_resp_data;

  modport master (
    input  miss_req_valid, miss_req_paddr, miss_req_way, miss_req_index,
    output miss_req_ready,
    output refill_valid, refill_paddr, refill_way, refill_data,
    input  refill_ready,
    input  wb_req_valid, wb_req_paddr, wb_req_data,
    output wb_req_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    output miss_req_valid, miss_req_paddr, miss_req_way, miss_req_index,
    input  miss_req_ready,
    input  refill_valid, refill_paddr, refill_way, refill_data,
    output refill_ready,
    output wb_req_valid, wb_req_paddr, wb_req_data,
    input  wb_req_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/dcache_miss_unit_wb_buffer.sv
// Single-entry writeback slice (paddr + line), used when DCACHE_MISS_WB_BUFFER_EN is defined.
module dcache_wb_buffer
  import dcache_miss_unit_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   in_valid_i,
  output logic   in_ready_o,
  input  paddr_t in_paddr_i,
  input  line_t  in_data_i,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output paddr_t out_paddr_o,
  output line_t  out_data_o
);

  logic   valid_q;
  paddr_t paddr_q;
  line_t  data_q;

  assign in_ready_o  = ~valid_q;
  assign out_valid_o = valid_q;
  assign out_paddr_o = paddr_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      paddr_q <= '0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      paddr_q <= in_paddr_i;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dcache_miss_unit.sv
// Line-to-beat miss/writeback engine behind the D-cache, one line transaction at a time.
// Optional one-entry writeback buffer: define DCACHE_MISS_WB_BUFFER_EN.
module dcache_miss_unit
  import dcache_miss_unit_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  dcache_miss_unit_if.master  bus,
  output logic [IndexW-1:0]   dbg_miss_index_o
);

  miss_state_e          state_q;
  cnt_t                 cnt_q;
  paddr_t               base_q;
  logic [SetAssocW-1:0] way_q;
  logic [IndexW-1:0]    index_q;
  line_t                line_q;
  logic                 mem_valid_q, mem_we_q, refill_valid_q;
  paddr_t               mem_addr_q;
  beat_t                mem_wdata_q;

  logic   idle, wb_pend, wb_take, miss_fire, last_beat;
  paddr_t wb_pend_paddr;
  line_t  wb_pend_data;
  cnt_t   cnt_nxt;

  assign idle      = (state_q == StIdle);
  assign cnt_nxt   = cnt_q + cnt_t'(1);
  assign last_beat = (cnt_q == cnt_t'(Beats - 1));

`ifdef DCACHE_MISS_WB_BUFFER_EN
  logic buf_in_ready;

  dcache_wb_buffer u_wb_buffer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (bus.wb_req_valid),
    .in_ready_o  (buf_in_ready),
    .in_paddr_i  (bus.wb_req_paddr),
    .in_data_i   (bus.wb_req_data),
    .out_valid_o (wb_pend),
    .out_ready_i (wb_take),
    .out_paddr_o (wb_pend_paddr),
    .out_data_o  (wb_pend_data)
  );

  assign bus.wb_req_ready = buf_in_ready & rst_ni;
  assign wb_take          = idle & wb_pend;
`else
  assign wb_pend          = bus.wb_req_valid;
  assign wb_pend_paddr    = bus.wb_req_paddr;
  assign wb_pend_data     = bus.wb_req_data;
  assign bus.wb_req_ready = idle & rst_ni;
  assign wb_take          = wb_pend & bus.wb_req_ready;
`endif

  // Pending writebacks win so a dirty victim reaches memory before its line is re-read.
  assign bus.miss_req_ready = idle & ~bus.wb_req_valid & ~wb_pend & rst_ni;
  assign miss_fire          = bus.miss_req_valid & bus.miss_req_ready;

  assign bus.mem_req_valid = mem_valid_q;
  assign bus.mem_req_we    = mem_we_q;
  assign bus.mem_req_addr  = mem_addr_q;
  assign bus.mem_req_wdata = mem_wdata_q;
  assign bus.refill_valid  = refill_valid_q;
  assign bus.refill_paddr  = base_q;
  assign bus.refill_way    = way_q;
  assign bus.refill_data   = line_q;
  assign dbg_miss_index_o  = index_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      base_q         <= '0;
      way_q          <= '0;
      index_q        <= '0;
      line_q         <= '0;
      mem_valid_q    <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      refill_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wb_take) begin
            base_q      <= line_base(wb_pend_paddr);
            line_q      <= wb_pend_data;
            cnt_q       <= '0;
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= line_base(wb_pend_paddr);
            mem_wdata_q <= get_beat(wb_pend_data, '0);
            state_q     <= StWb;
          end else if (miss_fire) begin
            base_q      <= line_base(bus.miss_req_paddr);
            way_q       <= bus.miss_req_way;
            index_q     <= bus.miss_req_index;
            cnt_q       <= '0;
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= line_base(bus.miss_req_paddr);
            state_q     <= StRdReq;
          end
        end
        StWb: begin
          if (bus.mem_req_ready) begin
            if (last_beat) begin
              mem_valid_q <= 1'b0;
              mem_we_q    <= 1'b0;
              state_q     <= StIdle;
            end else begin
              cnt_q       <= cnt_nxt;
              mem_addr_q  <= beat_addr(base_q, cnt_nxt);
              mem_wdata_q <= get_beat(line_q, cnt_nxt);
            end
          end
        end
        StRdReq: begin
          if (bus.mem_req_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= StRdWait;
          end
        end
        StRdWait: begin
          if (bus.mem_resp_valid) begin
            line_q[cnt_q*BeatW +: BeatW] <= bus.mem_resp_data;
            if (last_beat) begin
              refill_valid_q <= 1'b1;
              state_q        <= StRefill;
            end else begin
              cnt_q       <= cnt_nxt;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= beat_addr(base_q, cnt_nxt);
              state_q     <= StRdReq;
            end
          end
        end
        StRefill: begin
          if (bus.refill_ready) begin
            refill_valid_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_unit.sv
// Directed self-checking bench for dcache_miss_unit (256b line, 64b beats, zero-wait memory model).
module tb_dcache_miss_unit;
  import dcache_miss_unit_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IndexW-1:0] dbg_index;
  int                checks = 0;
  int                errors = 0;

  dcache_miss_unit_if bus ();

  dcache_miss_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bus              (bus),
    .dbg_miss_index_o (dbg_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] data;
  } beat_log_t;

  logic [63:0] mem_q [logic [31:0]];
  beat_log_t   log_q [$];

  // Memory: records every accepted beat, answers each read one cycle after acceptance.
  always @(posedge clk) begin : mem_model
    logic        rd;
    logic [63:0] rdata;
    rd    = 1'b0;
    rdata = '0;
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      log_q.push_back({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata});
      if (bus.mem_req_we) begin
        mem_q[bus.mem_req_addr] = bus.mem_req_wdata;
      end else begin
        rd    = 1'b1;
        rdata = mem_q.exists(bus.mem_req_addr) ? mem_q[bus.mem_req_addr] : 64'h0;
      end
    end
    #1;
    bus.mem_resp_valid = rd;
    bus.mem_resp_data  = rdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] base, input logic [63:0] seed);
    for (int k = 0; k < 4; k++) mem_q[base + 32'(k * 8)] = seed * 64'(k + 1);
  endtask

  // Leaves the caller in the cycle after acceptance; cyc = 2 there (accept cycle is 1).
  task automatic start_miss(input logic [31:0] paddr, input logic [1:0] way,
                            input logic [6:0] idx, output int cyc);
    int n = 0;
    bus.miss_req_valid = 1'b1;
    bus.miss_req_paddr = paddr;
    bus.miss_req_way   = way;
    bus.miss_req_index = idx;
    while (!bus.miss_req_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    bus.miss_req_valid = 1'b0;
    cyc = 2;
  endtask

  task automatic wait_refill(input string name, inout int cyc);
    int n = 0;
    while (!bus.refill_valid && n < 200) begin
      tick();
      cyc++;
      n++;
    end
    if (!bus.refill_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_refill_timeout: refill_valid=%b expected 1", name, bus.refill_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mem_valid: got %b exp 0", bus.mem_req_valid); end
    checks++; if (bus.refill_valid !== 1'b0) begin errors++;
      $display("FAIL rst_refill_valid: got %b exp 0", bus.refill_valid); end
    checks++; if (bus.miss_req_ready !== 1'b0) begin errors++;
      $display("FAIL rst_miss_ready: got %b exp 0", bus.miss_req_ready); end
    checks++; if (bus.wb_req_ready !== 1'b0) begin errors++;
      $display("FAIL rst_wb_ready: got %b exp 0", bus.wb_req_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.miss_req_ready !== 1'b1) begin errors++;
      $display("FAIL idle_miss_ready: got %b exp 1", bus.miss_req_ready); end
    checks++; if (bus.wb_req_ready !== 1'b1) begin errors++;
      $display("FAIL idle_wb_ready: got %b exp 1", bus.wb_req_ready); end
    checks++; if (bus.refill_paddr !== 32'h0 || bus.refill_data !== '0) begin errors++;
      $display("FAIL rst_regs: paddr %h data %h exp 0", bus.refill_paddr, bus.refill_data); end
    tick();
  endtask

  task automatic test_miss();
    int    cyc;
    line_t exp;
    exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    preload(32'h8000_1220, 64'h1111_1111_1111_1111);
    log_q.delete();
    start_miss(32'h8000_1234, 2'd2, 7'h11, cyc);
    wait_refill("miss", cyc);
    checks++; if (cyc !== 10) begin errors++;
      $display("FAIL miss_latency: got %0d cycles exp 10", cyc); end
    checks++; if (log_q.size() !== 4) begin errors++;
      $display("FAIL miss_beats: got %0d exp 4", log_q.size()); end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].we !== 1'b0 || log_q[k].addr !== 32'h8000_1220 + 32'(k * 8)) begin
        errors++;
        $display("FAIL miss_rd_addr%0d: got we=%b %h exp we=0 %h", k, log_q[k].we,
                 log_q[k].addr, 32'h8000_1220 + 32'(k * 8));
      end
    end
    checks++; if (bus.refill_paddr !== 32'h8000_1220) begin errors++;
      $display("FAIL miss_refill_paddr: got %h exp 80001220", bus.refill_paddr); end
    checks++; if (bus.refill_way !== 2'd2) begin errors++;
      $display("FAIL miss_refill_way: got %0d exp 2", bus.refill_way); end
    checks++; if (bus.refill_data !== exp) begin errors++;
      $display("FAIL miss_refill_data: got %h exp %h", bus.refill_data, exp); end
    checks++; if (dbg_index !== 7'h11) begin errors++;
      $display("FAIL miss_index: got %h exp 11", dbg_index); end
    tick();
    checks++; if (bus.refill_valid !== 1'b0) begin errors++;
      $display("FAIL miss_refill_drop: got %b exp 0", bus.refill_valid); end
  endtask

  task automatic test_wb_before_miss();
    int    cyc;
    int    n = 0;
    line_t d;
    d = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
         64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    log_q.delete();
    bus.wb_req_valid   = 1'b1;
    bus.wb_req_paddr   = 32'h8000_1220;
    bus.wb_req_data    = d;
    bus.miss_req_valid = 1'b1;
    bus.miss_req_paddr = 32'h8000_1220;
    bus.miss_req_way   = 2'd1;
    #0;
    checks++; if (bus.miss_req_ready !== 1'b0) begin errors++;
      $display("FAIL wbfirst_miss_ready: got %b exp 0", bus.miss_req_ready); end
    checks++; if (bus.wb_req_ready !== 1'b1) begin errors++;
      $display("FAIL wbfirst_wb_ready: got %b exp 1", bus.wb_req_ready); end
    tick();
    bus.wb_req_valid = 1'b0;
    while (!bus.miss_req_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    bus.miss_req_valid = 1'b0;
    cyc = 2;
    wait_refill("wbfirst", cyc);
    checks++; if (log_q.size() !== 8) begin errors++;
      $display("FAIL wbfirst_beats: got %0d exp 8", log_q.size()); end
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      logic        ewe;
      logic [31:0] ea;
      ewe = (k < 4);
      ea  = 32'h8000_1220 + 32'((k % 4) * 8);
      checks++;
      if (log_q[k].we !== ewe || log_q[k].addr !== ea ||
          (ewe && log_q[k].data !== d[(k%4)*64 +: 64])) begin
        errors++;
        $display("FAIL wbfirst_beat%0d: got we=%b %h %h exp we=%b %h", k, log_q[k].we,
                 log_q[k].addr, log_q[k].data, ewe, ea);
      end
    end
    checks++; if (bus.refill_data !== d || bus.refill_way !== 2'd1) begin errors++;
      $display("FAIL wbfirst_refill: got way %0d %h exp way 1 %h", bus.refill_way,
               bus.refill_data, d); end
    tick();
  endtask

  task automatic test_wb_stall();
    int    n = 0;
    line_t e;
    e = {64'hE3E3_E3E3_0000_1111, 64'hE2E2_E2E2_0000_2222,
         64'hE1E1_E1E1_0000_3333, 64'hE0E0_E0E0_0000_4444};
    log_q.delete();
    bus.wb_req_valid = 1'b1;
    bus.wb_req_paddr = 32'h8000_2010;
    bus.wb_req_data  = e;
    tick();
    bus.wb_req_valid = 1'b0;
    while (!bus.mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    checks++; if (bus.mem_req_addr !== 32'h8000_2000 || bus.mem_req_wdata !== e[63:0]) begin
      errors++; $display("FAIL stall_beat0: got %h %h exp 80002000 %h", bus.mem_req_addr,
                         bus.mem_req_wdata, e[63:0]); end
    tick();
    bus.mem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_we !== 1'b1 ||
          bus.mem_req_addr !== 32'h8000_2008 || bus.mem_req_wdata !== e[127:64]) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b we=%b %h %h exp v=1 we=1 80002008 %h", c,
                 bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata,
                 e[127:64]);
      end
    end
    bus.mem_req_ready = 1'b1;
    n = 0;
    while (bus.mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    checks++; if (log_q.size() !== 4) begin errors++;
      $display("FAIL stall_beats: got %0d exp 4", log_q.size()); end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].addr !== 32'h8000_2000 + 32'(k * 8) || log_q[k].data !== e[k*64 +: 64]) begin
        errors++;
        $display("FAIL stall_log%0d: got %h %h exp %h %h", k, log_q[k].addr, log_q[k].data,
                 32'h8000_2000 + 32'(k * 8), e[k*64 +: 64]);
      end
    end
  endtask

  task automatic test_refill_stall();
    int          cyc;
    line_t       exp;
    logic        wb_rdy_exp;
`ifdef DCACHE_MISS_WB_BUFFER_EN
    wb_rdy_exp = 1'b1;
`else
    wb_rdy_exp = 1'b0;
`endif
    exp = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
           64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    preload(32'h8000_4000, 64'h0101_0101_0101_0101);
    bus.refill_ready = 1'b0;
    start_miss(32'h8000_4004, 2'd3, 7'h00, cyc);
    wait_refill("rstall", cyc);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.refill_valid !== 1'b1 || bus.refill_paddr !== 32'h8000_4000 ||
          bus.refill_data !== exp || bus.miss_req_ready !== 1'b0 ||
          bus.wb_req_ready !== wb_rdy_exp) begin
        errors++;
        $display("FAIL rstall_hold%0d: got v=%b %h mrdy=%b wrdy=%b exp v=1 80004000 mrdy=0",
                 c, bus.refill_valid, bus.refill_paddr, bus.miss_req_ready, bus.wb_req_ready);
      end
      tick();
    end
    bus.refill_ready = 1'b1;
    tick();
    checks++; if (bus.refill_valid !== 1'b0 || bus.miss_req_ready !== 1'b1) begin errors++;
      $display("FAIL rstall_release: got v=%b mrdy=%b exp v=0 mrdy=1", bus.refill_valid,
               bus.miss_req_ready); end
  endtask

  task automatic test_reset_mid();
    int    cyc;
    int    n = 0;
    line_t exp;
    exp = {64'h3C3C_3C3C_3C3C_3C3C, 64'h2D2D_2D2D_2D2D_2D2D,
           64'h1E1E_1E1E_1E1E_1E1E, 64'h0F0F_0F0F_0F0F_0F0F};
    preload(32'h8000_5000, 64'h0F0F_0F0F_0F0F_0F0F);
    log_q.delete();
    start_miss(32'h8000_5008, 2'd3, 7'h05, cyc);
    while (log_q.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0 || bus.refill_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_valids: got mem=%b refill=%b exp 0 0", bus.mem_req_valid,
               bus.refill_valid); end
    checks++; if (bus.refill_paddr !== 32'h0 || bus.refill_data !== '0) begin errors++;
      $display("FAIL midrst_regs: got %h %h exp 0", bus.refill_paddr, bus.refill_data); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    log_q.delete();
    start_miss(32'h8000_5010, 2'd0, 7'h05, cyc);
    wait_refill("midrst", cyc);
    checks++; if (cyc !== 10 || log_q.size() !== 4) begin errors++;
      $display("FAIL midrst_after: got %0d cycles %0d beats exp 10 4", cyc, log_q.size()); end
    checks++; if (bus.refill_data !== exp || bus.refill_paddr !== 32'h8000_5000) begin errors++;
      $display("FAIL midrst_data: got %h %h exp 80005000 %h", bus.refill_paddr,
               bus.refill_data, exp); end
    tick();
  endtask

`ifdef DCACHE_MISS_WB_BUFFER_EN
  task automatic test_wb_buffer();
    int    cyc;
    int    n = 0;
    line_t f;
    f = {64'hF3F3_0000_0000_F3F3, 64'hF2F2_0000_0000_F2F2,
         64'hF1F1_0000_0000_F1F1, 64'hF0F0_0000_0000_F0F0};
    preload(32'h8000_6000, 64'h0707_0707_0707_0707);
    log_q.delete();
    start_miss(32'h8000_6000, 2'd1, 7'h00, cyc);
    while (log_q.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    bus.wb_req_valid = 1'b1;
    bus.wb_req_paddr = 32'h8000_7000;
    bus.wb_req_data  = f;
    #0;
    checks++; if (bus.wb_req_ready !== 1'b1) begin errors++;
      $display("FAIL buf_accept: got %b exp 1", bus.wb_req_ready); end
    tick();
    bus.wb_req_valid   = 1'b0;
    bus.miss_req_valid = 1'b1;
    bus.miss_req_paddr = 32'h8000_6000;
    wait_refill("buf1", cyc);
    tick();
    n = 0;
    while (!bus.miss_req_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.miss_req_valid = 1'b0;
    wait_refill("buf2", cyc);
    tick();
    checks++; if (log_q.size() !== 12) begin errors++;
      $display("FAIL buf_beats: got %0d exp 12", log_q.size()); end
    for (int k = 0; k < 12 && k < log_q.size(); k++) begin
      logic        ewe;
      logic [31:0] ea;
      ewe = (k >= 4 && k < 8);
      ea  = (ewe ? 32'h8000_7000 : 32'h8000_6000) + 32'((k % 4) * 8);
      checks++;
      if (log_q[k].we !== ewe || log_q[k].addr !== ea) begin
        errors++;
        $display("FAIL buf_order%0d: got we=%b %h exp we=%b %h", k, log_q[k].we,
                 log_q[k].addr, ewe, ea);
      end
    end
  endtask
`endif

  initial begin
    bus.miss_req_valid = 1'b0;
    bus.miss_req_paddr = '0;
    bus.miss_req_way   = '0;
    bus.miss_req_index = '0;
    bus.refill_ready   = 1'b1;
    bus.wb_req_valid   = 1'b0;
    bus.wb_req_paddr   = '0;
    bus.wb_req_data    = '0;
    bus.mem_req_ready  = 1'b1;
    test_reset();
    test_miss();
    test_wb_before_miss();
    test_wb_stall();
    test_refill_stall();
    test_reset_mid();
`ifdef DCACHE_MISS_WB_BUFFER_EN
    test_wb_buffer();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
